// File: rtl/call_panel_debounce.sv
// call_panel_debounce: synchronizes and debounces ten call buttons into fixed-width request strobes
// Ports:
//   clk        controller clock
//   rst_n      asynchronous active-low reset
//   key_raw    raw pins [0..3] car 1..4, [4] hall 1 up, [5] 2 up, [6] 2 down, [7] 3 up, [8] 3 down, [9] 4 down
//   kin*       one strobe of PULSE_CYCLES clocks per debounced press
//   last_key   index of the most recently accepted key, 4'hF when none since reset
//   press_cnt  accepted presses modulo 256
module call_panel_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_CYCLES = 2,
    parameter bit RAW_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] key_raw,
    output logic       kin1,
    output logic       kin2,
    output logic       kin3,
    output logic       kin4,
    output logic       kin1_up,
    output logic       kin2_up,
    output logic       kin2_down,
    output logic       kin3_up,
    output logic       kin3_down,
    output logic       kin4_down,
    output logic [3:0] last_key,
    output logic [7:0] press_cnt
);
    typedef enum logic [2:0] {IDLE, PRESS_CHK, FIRE, HELD, REL_CHK} state_t;

    localparam logic [9:0] REL_LEVEL = {10{RAW_ACTIVE_LOW}};
    localparam logic [7:0] DB = 8'(DEBOUNCE_CYCLES);
    localparam logic [3:0] PW = 4'(PULSE_CYCLES);

    logic [9:0] sync1, sync2, pressed, strobe, acc;
    logic [7:0] add;
    logic [3:0] sel;

    // Synchronizer holds the raw level; it resets to "released" so a key held
    // through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= REL_LEVEL;
            sync2 <= REL_LEVEL;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    assign pressed = sync2 ^ REL_LEVEL;

    for (genvar k = 0; k < 10; k++) begin : g_key
        state_t st;
        logic [7:0] dc;
        logic [3:0] pc;
        logic str;
        assign acc[k] = st == PRESS_CHK && pressed[k] && dc == DB;
        assign strobe[k] = str;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st <= IDLE;
                dc <= '0;
                pc <= '0;
                str <= 1'b0;
            end else begin
                str <= 1'b0;
                case (st)
                    IDLE: if (pressed[k]) begin
                        st <= PRESS_CHK;
                        dc <= 8'd1;
                    end
                    PRESS_CHK: if (!pressed[k]) begin
                        st <= IDLE;
                        dc <= '0;
                    end else if (dc == DB) begin
                        st <= FIRE;
                        dc <= '0;
                        pc <= 4'd1;
                        str <= 1'b1;
                    end else dc <= dc + 8'd1;
                    // The key level is ignored here so a release cannot cut the strobe short.
                    FIRE: if (pc == PW) begin
                        st <= HELD;
                        pc <= '0;
                    end else begin
                        pc <= pc + 4'd1;
                        str <= 1'b1;
                    end
                    HELD: if (!pressed[k]) begin
                        st <= REL_CHK;
                        dc <= 8'd1;
                    end
                    REL_CHK: if (pressed[k]) begin
                        st <= HELD;
                        dc <= '0;
                    end else if (dc == DB) begin
                        st <= IDLE;
                        dc <= '0;
                    end else dc <= dc + 8'd1;
                    default: st <= IDLE;
                endcase
            end
        end
    end

    // Descending scan so the lowest accepted index is the one left in sel.
    always_comb begin
        add = '0;
        sel = 4'hF;
        for (int i = 9; i >= 0; i--) begin
            if (acc[i]) begin
                add = add + 8'd1;
                sel = 4'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_key <= 4'hF;
            press_cnt <= '0;
        end else begin
            press_cnt <= press_cnt + add;
            if (|acc) last_key <= sel;
        end
    end

    assign kin1 = strobe[0];
    assign kin2 = strobe[1];
    assign kin3 = strobe[2];
    assign kin4 = strobe[3];
    assign kin1_up = strobe[4];
    assign kin2_up = strobe[5];
    assign kin2_down = strobe[6];
    assign kin3_up = strobe[7];
    assign kin3_down = strobe[8];
    assign kin4_down = strobe[9];
endmodule

// File: tb/tb_call_panel_debounce.sv
// tb_call_panel_debounce: scoreboard bench for call_panel_debounce with default parameters
module tb_call_panel_debounce;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [9:0] key_raw = '1;
    logic kin1, kin2, kin3, kin4, kin1_up, kin2_up, kin2_down, kin3_up, kin3_down, kin4_down;
    logic [3:0] last_key;
    logic [7:0] press_cnt;
    logic [9:0] s;

    typedef struct {
        int rise;
        logic [9:0] keys;
        logic [3:0] lk;
        logic [7:0] pc;
    } exp_t;

    exp_t q[$];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_cnt = '0;

    call_panel_debounce dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_raw(key_raw),
        .kin1(kin1),
        .kin2(kin2),
        .kin3(kin3),
        .kin4(kin4),
        .kin1_up(kin1_up),
        .kin2_up(kin2_up),
        .kin2_down(kin2_down),
        .kin3_up(kin3_up),
        .kin3_down(kin3_down),
        .kin4_down(kin4_down),
        .last_key(last_key),
        .press_cnt(press_cnt)
    );

    assign s = {kin4_down, kin3_down, kin3_up, kin2_down, kin2_up, kin1_up, kin4, kin3, kin2, kin1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge right as the key goes down: the next posedge is E0 and
    // the strobe rises on E0+6 (2 sync flops + 4 debounce samples), seen at cyc+7.
    task automatic expect_strobe(input logic [9:0] keys, input logic [3:0] lk);
        exp_t e;
        exp_cnt = exp_cnt + 8'($countones(keys));
        e.rise = cyc + 7;
        e.keys = keys;
        e.lk = lk;
        e.pc = exp_cnt;
        q.push_back(e);
    endtask

    task automatic press_once(input int k);
        key_raw[k] = 1'b0;
        expect_strobe(10'(1 << k), 4'(k));
        tick(10);
        key_raw[k] = 1'b1;
        tick(8);
    endtask

    // Monitor: pops one expectation per strobe rise and checks every pulse width.
    initial begin
        logic [9:0] prev;
        int hi;
        exp_t e;
        prev = '0;
        hi = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) hi = 0;
            else begin
                if ((s & ~prev) != 0) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL unexpected_strobe: got %b at cycle %0d, want none", s, cyc);
                    end else begin
                        e = q.pop_front();
                        chk("rise_cycle", cyc, e.rise);
                        chk("strobe_keys", 32'(s), 32'(e.keys));
                        chk("last_key", 32'(last_key), 32'(e.lk));
                        chk("press_cnt", 32'(press_cnt), 32'(e.pc));
                    end
                end
                if (s != 0) hi++;
                else if (prev != 0) begin
                    chk("strobe_width", hi, 2);
                    hi = 0;
                end
            end
            prev = s;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    initial begin
        tick(3);
        chk("rst_strobes", 32'(s), 0);
        chk("rst_last_key", 32'(last_key), 32'hF);
        chk("rst_press_cnt", 32'(press_cnt), 0);
        rst_n = 1'b1;
        tick(2);
        // single clean press, car 3
        key_raw[2] = 1'b0;
        expect_strobe(10'b00_0000_0100, 4'd2);
        tick(20);
        key_raw[2] = 1'b1;
        tick(12);
        // press bounce on hall 2 down: 2 on, 1 off, 3 on, 1 off, then steady
        key_raw[6] = 1'b0;
        tick(2);
        key_raw[6] = 1'b1;
        tick(1);
        key_raw[6] = 1'b0;
        tick(3);
        key_raw[6] = 1'b1;
        tick(1);
        key_raw[6] = 1'b0;
        expect_strobe(10'b00_0100_0000, 4'd6);
        tick(20);
        key_raw[6] = 1'b1;
        tick(12);
        // held hall 4 down with a 2-clock release glitch, then a real re-press
        key_raw[9] = 1'b0;
        expect_strobe(10'b10_0000_0000, 4'd9);
        tick(50);
        key_raw[9] = 1'b1;
        tick(2);
        key_raw[9] = 1'b0;
        tick(48);
        key_raw[9] = 1'b1;
        tick(8);
        key_raw[9] = 1'b0;
        expect_strobe(10'b10_0000_0000, 4'd9);
        tick(20);
        key_raw[9] = 1'b1;
        tick(12);
        // simultaneous car 1 and hall 2 up
        key_raw[5] = 1'b0;
        key_raw[0] = 1'b0;
        expect_strobe(10'b00_0010_0001, 4'd0);
        tick(20);
        key_raw[5] = 1'b1;
        key_raw[0] = 1'b1;
        tick(12);
        // release right after the strobe rises: width must stay 2
        key_raw[4] = 1'b0;
        expect_strobe(10'b00_0001_0000, 4'd4);
        tick(7);
        key_raw[4] = 1'b1;
        tick(15);
        // reset during the kin4 strobe with the key held
        key_raw[3] = 1'b0;
        expect_strobe(10'b00_0000_1000, 4'd3);
        tick(7);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_strobes", 32'(s), 0);
        chk("midrst_last_key", 32'(last_key), 32'hF);
        chk("midrst_press_cnt", 32'(press_cnt), 0);
        exp_cnt = '0;
        @(negedge clk);
        rst_n = 1'b1;
        expect_strobe(10'b00_0000_1000, 4'd3);
        tick(20);
        key_raw[3] = 1'b1;
        tick(12);
        // counter wrap over 257 presses from a fresh reset
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        exp_cnt = '0;
        tick(2);
        for (int i = 0; i < 257; i++) press_once(1);
        tick(5);
        chk("final_press_cnt", 32'(press_cnt), 1);
        chk("final_last_key", 32'(last_key), 1);
        chk("queue_drained", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
